// File: rtl/lemmings_array.sv
// N independent lemming walker FSMs sharing one clock and async reset,
// with per-lane fall timing, respawn out of SPLAT and a saturating splat tally.
module lemmings_array #(
    parameter int N_LEM        = 4,
    parameter int SPLAT_CYCLES = 20,
    parameter int CNT_W        = 5,
    parameter int TOT_W        = 8
) (
    input  logic             clk,
    input  logic             areset_n,
    input  logic [N_LEM-1:0] bump_left,
    input  logic [N_LEM-1:0] bump_right,
    input  logic [N_LEM-1:0] ground,
    input  logic [N_LEM-1:0] dig,
    input  logic [N_LEM-1:0] respawn,
    output logic [N_LEM-1:0] walk_left,
    output logic [N_LEM-1:0] walk_right,
    output logic [N_LEM-1:0] aaah,
    output logic [N_LEM-1:0] digging,
    output logic [N_LEM-1:0] splat,
    output logic             all_dead,
    output logic [TOT_W-1:0] splat_total
);

    typedef enum logic [2:0] {
        WALK_L, WALK_R, DIG_L, DIG_R, FALL_L, FALL_R, SPLAT
    } state_t;

    localparam int PC_W = $clog2(N_LEM + 1);
    localparam logic [CNT_W-1:0] SPLAT_TH = CNT_W'(SPLAT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [TOT_W:0]   TOT_MAX  = {1'b0, {TOT_W{1'b1}}};

    state_t           state_q [N_LEM];
    state_t           state_d [N_LEM];
    logic [CNT_W-1:0] cnt_q   [N_LEM];
    logic [CNT_W-1:0] cnt_d   [N_LEM];
    logic [N_LEM-1:0] land_splat;
    logic [PC_W-1:0]  n_splat;
    logic [TOT_W:0]   tot_sum;
    logic [TOT_W-1:0] tot_d;

    always_comb begin
        for (int i = 0; i < N_LEM; i++) begin
            state_d[i]    = state_q[i];
            land_splat[i] = 1'b0;
            unique case (state_q[i])
                WALK_L: begin
                    if (!ground[i])         state_d[i] = FALL_L;
                    else if (dig[i])        state_d[i] = DIG_L;
                    else if (bump_left[i])  state_d[i] = WALK_R;
                end
                WALK_R: begin
                    if (!ground[i])         state_d[i] = FALL_R;
                    else if (dig[i])        state_d[i] = DIG_R;
                    else if (bump_right[i]) state_d[i] = WALK_L;
                end
                DIG_L: if (!ground[i]) state_d[i] = FALL_L;
                DIG_R: if (!ground[i]) state_d[i] = FALL_R;
                FALL_L, FALL_R: begin
                    if (ground[i]) begin
                        if (cnt_q[i] >= SPLAT_TH) begin
                            state_d[i]    = SPLAT;
                            land_splat[i] = 1'b1;
                        end else begin
                            state_d[i] = (state_q[i] == FALL_L) ? WALK_L : WALK_R;
                        end
                    end
                end
                SPLAT: if (respawn[i]) state_d[i] = WALK_L;
                default: state_d[i] = WALK_L;
            endcase
            // Counter only runs while staying in FALL, so it is 0 elsewhere.
            cnt_d[i] = '0;
            if ((state_q[i] == FALL_L || state_q[i] == FALL_R) &&
                (state_d[i] == FALL_L || state_d[i] == FALL_R))
                cnt_d[i] = (cnt_q[i] == CNT_MAX) ? CNT_MAX : cnt_q[i] + 1'b1;
        end
    end

    always_comb begin
        n_splat = '0;
        for (int i = 0; i < N_LEM; i++)
            n_splat = n_splat + PC_W'(land_splat[i]);
        tot_sum = (TOT_W+1)'(splat_total) + (TOT_W+1)'(n_splat);
        tot_d   = (tot_sum > TOT_MAX) ? '1 : tot_sum[TOT_W-1:0];
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            for (int i = 0; i < N_LEM; i++) begin
                state_q[i] <= WALK_L;
                cnt_q[i]   <= '0;
            end
            splat_total <= '0;
        end else begin
            for (int i = 0; i < N_LEM; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            splat_total <= tot_d;
        end
    end

    always_comb begin
        for (int i = 0; i < N_LEM; i++) begin
            walk_left[i]  = (state_q[i] == WALK_L);
            walk_right[i] = (state_q[i] == WALK_R);
            aaah[i]       = (state_q[i] == FALL_L) || (state_q[i] == FALL_R);
            digging[i]    = (state_q[i] == DIG_L) || (state_q[i] == DIG_R);
            splat[i]      = (state_q[i] == SPLAT);
        end
    end

    assign all_dead = &splat;

endmodule

// File: tb/tb_lemmings_array.sv
// Randomised and directed checks of lemmings_array against a behavioural
// lane model that tracks direction, activity and fall length in plain ints.
module tb_lemmings_array;

    localparam int N   = 4;
    localparam int SPL = 20;
    localparam int TMAX = 255;

    logic         clk = 1'b0;
    logic         areset_n;
    logic [N-1:0] bump_left, bump_right, ground, dig, respawn;
    logic [N-1:0] walk_left, walk_right, aaah, digging, splat;
    logic         all_dead;
    logic [7:0]   splat_total;

    int n_chk  = 0;
    int n_fail = 0;

    lemmings_array #(.N_LEM(N), .SPLAT_CYCLES(SPL), .CNT_W(5), .TOT_W(8)) dut (
        .clk(clk), .areset_n(areset_n),
        .bump_left(bump_left), .bump_right(bump_right),
        .ground(ground), .dig(dig), .respawn(respawn),
        .walk_left(walk_left), .walk_right(walk_right), .aaah(aaah),
        .digging(digging), .splat(splat), .all_dead(all_dead),
        .splat_total(splat_total)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: act 0=walk 1=dig 2=fall 3=dead; dir 0=left 1=right.
    int m_act   [N];
    int m_dir   [N];
    int m_falls [N];
    int m_total;

    always @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            for (int i = 0; i < N; i++) begin
                m_act[i] = 0; m_dir[i] = 0; m_falls[i] = 0;
            end
            m_total = 0;
        end else begin
            int splats;
            splats = 0;
            for (int i = 0; i < N; i++) begin
                case (m_act[i])
                    0: begin
                        if (!ground[i]) begin m_act[i] = 2; m_falls[i] = 1; end
                        else if (dig[i]) m_act[i] = 1;
                        else if (m_dir[i] == 0 && bump_left[i]) m_dir[i] = 1;
                        else if (m_dir[i] == 1 && bump_right[i]) m_dir[i] = 0;
                    end
                    1: if (!ground[i]) begin m_act[i] = 2; m_falls[i] = 1; end
                    2: begin
                        if (!ground[i]) m_falls[i]++;
                        else if (m_falls[i] > SPL) begin m_act[i] = 3; splats++; end
                        else m_act[i] = 0;
                    end
                    default: if (respawn[i]) begin m_act[i] = 0; m_dir[i] = 0; end
                endcase
            end
            m_total = (m_total + splats > TMAX) ? TMAX : m_total + splats;
        end
    end

    always @(negedge clk) begin
        logic [N-1:0] e_wl, e_wr, e_ah, e_dg, e_sp;
        for (int i = 0; i < N; i++) begin
            e_wl[i] = (m_act[i] == 0 && m_dir[i] == 0);
            e_wr[i] = (m_act[i] == 0 && m_dir[i] == 1);
            e_ah[i] = (m_act[i] == 2);
            e_dg[i] = (m_act[i] == 1);
            e_sp[i] = (m_act[i] == 3);
        end
        check("walk_left",   32'(walk_left),   32'(e_wl));
        check("walk_right",  32'(walk_right),  32'(e_wr));
        check("aaah",        32'(aaah),        32'(e_ah));
        check("digging",     32'(digging),     32'(e_dg));
        check("splat",       32'(splat),       32'(e_sp));
        check("all_dead",    32'(all_dead),    32'(&e_sp));
        check("splat_total", 32'(splat_total), 32'(m_total));
    end

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic idle();
        bump_left = '0; bump_right = '0; dig = '0; respawn = '0;
    endtask

    initial begin
        int low_left [N];
        int ah_cnt;
        areset_n = 1'b0;
        ground = '1;
        idle();
        @(negedge clk);
        @(negedge clk);
        areset_n = 1'b1;

        // 1: idle after reset
        step(5);
        check("t1_walk_left", 32'(walk_left), 32'h f);
        check("t1_total", 32'(splat_total), 32'd0);

        // 2: bump turns, dig beats bump
        bump_left[0] = 1'b1; step(1); idle();
        check("t2_turn", 32'(walk_right[0]), 32'd1);
        bump_right[0] = 1'b1; dig[0] = 1'b1; step(1); idle();
        check("t2_dig", 32'(digging[0]), 32'd1);

        // 3: 20-cycle fall survives, 21-cycle fall splats
        ground[1] = 1'b0;
        ah_cnt = 0;
        for (int k = 0; k < 20; k++) begin
            step(1);
            if (aaah[1]) ah_cnt++;
        end
        check("t3_aaah_len", 32'(ah_cnt), 32'd20);
        ground[1] = 1'b1; step(1);
        check("t3_survive", 32'(walk_left[1]), 32'd1);
        ground[1] = 1'b0; step(21);
        ground[1] = 1'b1; step(1);
        check("t3_splat", 32'(splat[1]), 32'd1);
        check("t3_total", 32'(splat_total), 32'd1);

        // 4: two lanes land together, then respawn one
        ground[0] = 1'b0; ground[2] = 1'b0; step(25);
        ground = '1; step(1);
        check("t4_splat", 32'(splat), 32'h7);
        check("t4_total", 32'(splat_total), 32'd3);
        respawn[2] = 1'b1; step(1); idle();
        check("t4_respawn", 32'(walk_left[2]), 32'd1);
        check("t4_total_kept", 32'(splat_total), 32'd3);

        // 5: 40-cycle fall saturates counter, then everyone dies
        ground[3] = 1'b0; step(40);
        check("t5_falling", 32'(aaah[3]), 32'd1);
        ground[3] = 1'b1; step(1);
        check("t5_splat", 32'(splat[3]), 32'd1);
        check("t5_not_all", 32'(all_dead), 32'd0);
        ground[2] = 1'b0; step(22);
        ground[2] = 1'b1; step(1);
        check("t5_all_dead", 32'(all_dead), 32'd1);
        check("t5_total", 32'(splat_total), 32'd5);
        respawn = '1; step(1); idle();
        check("t5_revive", 32'(walk_left), 32'h f);

        // 6: async reset mid-fall clears the counter
        ground[3] = 1'b0; step(10);
        #2 areset_n = 1'b0;
        ground = '1;
        #1;
        check("t6_async_wl", 32'(walk_left), 32'h f);
        check("t6_async_tot", 32'(splat_total), 32'd0);
        @(negedge clk);
        areset_n = 1'b1;
        ground[3] = 1'b0; step(20);
        ground[3] = 1'b1; step(1);
        check("t6_survive", 32'(walk_left[3]), 32'd1);

        // splat_total saturation
        for (int r = 0; r < 70; r++) begin
            ground = '0; step(22);
            ground = '1; step(1);
            respawn = '1; step(1); idle();
        end
        check("sat_total", 32'(splat_total), 32'd255);

        // random traffic
        for (int i = 0; i < N; i++) low_left[i] = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (low_left[i] > 0) begin
                    ground[i] = 1'b0;
                    low_left[i]--;
                end else begin
                    ground[i] = 1'b1;
                    if ($urandom_range(15) == 0) low_left[i] = $urandom_range(30, 1);
                end
                bump_left[i]  = ($urandom_range(3) == 0);
                bump_right[i] = ($urandom_range(3) == 0);
                dig[i]        = ($urandom_range(7) == 0);
                respawn[i]    = ($urandom_range(5) == 0);
            end
            if ($urandom_range(499) == 0) begin
                #3 areset_n = 1'b0;
                @(negedge clk);
                areset_n = 1'b1;
            end else begin
                step(1);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
